// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style priority controller.
//   ir_level_t  : 3-bit interrupt level index
//   pic_state_t : acknowledge sequencer states
//   rotate_vec  : rotates a request vector so that bit 0 holds the
//                 highest-priority level (lowest_prio + 1)
package pic_pkg;

  localparam int PIC_NUM_IR = 8;

  typedef logic [2:0] ir_level_t;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACK1,
    ACK2
  } pic_state_t;

  // Result bit i holds vec[lowest_prio + 1 + i] (mod 8), so the
  // lowest set bit of the result is the highest-priority request.
  function automatic logic [PIC_NUM_IR-1:0] rotate_vec(
    input logic [PIC_NUM_IR-1:0] vec,
    input ir_level_t             lowest_prio
  );
    logic [PIC_NUM_IR-1:0] r;
    ir_level_t             src;
    for (int i = 0; i < PIC_NUM_IR; i++) begin
      src  = lowest_prio + ir_level_t'(i + 1);
      r[i] = vec[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational priority resolver.
//   vec         : input request/in-service vector
//   lowest_prio : level currently holding the lowest priority
//   valid       : at least one bit of vec is set
//   index       : level of the highest-priority set bit
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [PIC_NUM_IR-1:0] vec,
  input  ir_level_t             lowest_prio,
  output logic                  valid,
  output ir_level_t             index
);

  logic [PIC_NUM_IR-1:0] rot;
  ir_level_t             pos;

  // Scan downwards so the lowest set rotated position is the one kept.
  always_comb begin
    rot   = rotate_vec(vec, lowest_prio);
    pos   = '0;
    valid = 1'b0;
    for (int i = PIC_NUM_IR - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos   = ir_level_t'(i);
        valid = 1'b1;
      end
    end
  end

  // Undo the rotation to recover the absolute level.
  assign index = lowest_prio + 3'd1 + pos;

endmodule

// File: rtl/pic_priority_controller.sv
// 8259-style interrupt sequencer: resolves masked requests against the
// in-service register, raises INT, runs the two-pulse INTA handshake,
// drives the vector byte and handles normal/specific/automatic EOI with
// optional priority rotation.
//   clk, rst_n     : clock, asynchronous active-low reset
//   irr            : masked pending requests
//   inta_n         : CPU acknowledge (active low, synchronous)
//   eoi_valid      : one-cycle EOI strobe
//   eoi_specific   : 1 = clear eoi_level, 0 = clear highest in-service
//   eoi_level      : target level of a specific EOI
//   rotate_on_eoi  : cleared level becomes lowest priority
//   auto_eoi       : clear ISR bit when the second INTA ends
//   vector_base    : upper five bits of the vector byte
//   int_out        : interrupt request to the CPU
//   clear_irr      : one-cycle clear pulse for the acknowledged request
//   freeze         : high from first INTA until second INTA completes
//   isr            : in-service register
//   data_out       : vector byte, data_out_en its bus drive enable
module pic_priority_controller
  import pic_pkg::*;
#(
  parameter int NUM_IR      = 8,
  parameter int SPURIOUS_IR = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] irr,
  input  logic              inta_n,
  input  logic              eoi_valid,
  input  logic              eoi_specific,
  input  logic [2:0]        eoi_level,
  input  logic              rotate_on_eoi,
  input  logic              auto_eoi,
  input  logic [4:0]        vector_base,
  output logic              int_out,
  output logic [NUM_IR-1:0] clear_irr,
  output logic              freeze,
  output logic [NUM_IR-1:0] isr,
  output logic [7:0]        data_out,
  output logic              data_out_en
);

  pic_state_t        state_q, state_d;
  logic              int_q, int_d, freeze_q, freeze_d, den_q, den_d;
  logic              gen_q, gen_d, inta_n_q;
  logic [NUM_IR-1:0] clr_q, clr_d, isr_q, isr_d, set_mask, clr_mask;
  logic [7:0]        dout_q, dout_d;
  ir_level_t         lp_q, lp_d, lvl_q, lvl_d;

  logic              cand_valid, blk_valid, eligible, inta_fall, inta_rise;
  ir_level_t         cand_idx, blk_idx, cand_rank, blk_rank;

  pic_priority_resolver u_irr_res (
    .vec         (irr),
    .lowest_prio (lp_q),
    .valid       (cand_valid),
    .index       (cand_idx)
  );

  pic_priority_resolver u_isr_res (
    .vec         (isr_q),
    .lowest_prio (lp_q),
    .valid       (blk_valid),
    .index       (blk_idx)
  );

  // Rank 0 is the highest priority (level lowest_prio + 1).
  assign cand_rank = cand_idx - lp_q - 3'd1;
  assign blk_rank  = blk_idx - lp_q - 3'd1;
  assign eligible  = cand_valid & (~blk_valid | (cand_rank < blk_rank));
  assign inta_fall = inta_n_q & ~inta_n;
  assign inta_rise = ~inta_n_q & inta_n;

  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    clr_d    = '0;
    freeze_d = freeze_q;
    dout_d   = dout_q;
    den_d    = den_q;
    lp_d     = lp_q;
    lvl_d    = lvl_q;
    gen_d    = gen_q;
    set_mask = '0;
    clr_mask = '0;

    case (state_q)
      IDLE: begin
        if (eligible) begin
          int_d   = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (inta_fall) begin
          int_d    = 1'b0;
          freeze_d = 1'b1;
          state_d  = ACK1;
          if (eligible) begin
            lvl_d    = cand_idx;
            gen_d    = 1'b1;
            set_mask = NUM_IR'(1) << cand_idx;
            clr_d    = NUM_IR'(1) << cand_idx;
          end else begin
            // Request withdrawn before acknowledge: report spurious level.
            lvl_d = ir_level_t'(SPURIOUS_IR);
            gen_d = 1'b0;
          end
        end else if (!eligible) begin
          int_d   = 1'b0;
          state_d = IDLE;
        end
      end
      ACK1: begin
        if (inta_fall) begin
          dout_d  = {vector_base, lvl_q};
          den_d   = 1'b1;
          state_d = ACK2;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          den_d    = 1'b0;
          freeze_d = 1'b0;
          state_d  = IDLE;
          if (auto_eoi && gen_q) begin
            clr_mask = NUM_IR'(1) << lvl_q;
            if (rotate_on_eoi) lp_d = lvl_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // EOI works on the pre-update ISR; an ISR set in the same cycle wins.
    if (eoi_valid) begin
      if (eoi_specific) begin
        if (isr_q[eoi_level]) begin
          clr_mask = clr_mask | (NUM_IR'(1) << eoi_level);
          if (rotate_on_eoi) lp_d = eoi_level;
        end
      end else if (blk_valid) begin
        clr_mask = clr_mask | (NUM_IR'(1) << blk_idx);
        if (rotate_on_eoi) lp_d = blk_idx;
      end
    end

    isr_d = (isr_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      int_q    <= 1'b0;
      clr_q    <= '0;
      freeze_q <= 1'b0;
      isr_q    <= '0;
      dout_q   <= '0;
      den_q    <= 1'b0;
      lp_q     <= 3'd7;
      lvl_q    <= '0;
      gen_q    <= 1'b0;
      inta_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      int_q    <= int_d;
      clr_q    <= clr_d;
      freeze_q <= freeze_d;
      isr_q    <= isr_d;
      dout_q   <= dout_d;
      den_q    <= den_d;
      lp_q     <= lp_d;
      lvl_q    <= lvl_d;
      gen_q    <= gen_d;
      inta_n_q <= inta_n;
    end
  end

  assign int_out     = int_q;
  assign clear_irr   = clr_q;
  assign freeze      = freeze_q;
  assign isr         = isr_q;
  assign data_out    = dout_q;
  assign data_out_en = den_q;

endmodule

// File: tb/tb_pic_priority_controller.sv
module tb_pic_priority_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irr = 8'h00;
  logic       inta_n = 1'b1;
  logic       eoi_valid = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic       rotate_on_eoi = 1'b0;
  logic       auto_eoi = 1'b0;
  logic [4:0] vector_base = 5'h08;
  logic       int_out, freeze, data_out_en;
  logic [7:0] clear_irr, isr, data_out;

  always #5 clk = ~clk;

  pic_priority_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irr           (irr),
    .inta_n        (inta_n),
    .eoi_valid     (eoi_valid),
    .eoi_specific  (eoi_specific),
    .eoi_level     (eoi_level),
    .rotate_on_eoi (rotate_on_eoi),
    .auto_eoi      (auto_eoi),
    .vector_base   (vector_base),
    .int_out       (int_out),
    .clear_irr     (clear_irr),
    .freeze        (freeze),
    .isr           (isr),
    .data_out      (data_out),
    .data_out_en   (data_out_en)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: handshake phase 0=idle,1=int raised,2=after 1st INTA,3=after 2nd INTA
  int         m_phase, m_lp, m_lvl;
  bit         m_gen, m_prev;
  logic       m_int, m_freeze, m_den;
  logic [7:0] m_clr, m_isr, m_dout;

  task automatic m_reset();
    m_phase = 0; m_lp = 7; m_lvl = 0; m_gen = 0; m_prev = 1;
    m_int = 0; m_freeze = 0; m_den = 0; m_clr = 0; m_isr = 0; m_dout = 0;
  endtask

  // Highest-priority set level of v, scanning lp+1, lp+2, ... ; -1 if none.
  function automatic int top_level(input logic [7:0] v, input int lp);
    for (int k = 1; k <= 8; k++) begin
      int l;
      l = (lp + k) % 8;
      if (v[l]) return l;
    end
    return -1;
  endfunction

  function automatic int rank_of(input int l, input int lp);
    return (l - lp - 1 + 16) % 8;
  endfunction

  task automatic model_step();
    int c, b;
    bit elig, fall, rise;
    logic [7:0] old_isr, set_m;
    fall = m_prev && !inta_n;
    rise = !m_prev && inta_n;
    m_prev = inta_n;
    old_isr = m_isr;
    c = top_level(irr, m_lp);
    b = top_level(old_isr, m_lp);
    elig = (c >= 0) && ((b < 0) || (rank_of(c, m_lp) < rank_of(b, m_lp)));
    set_m = 0;
    m_clr = 0;
    case (m_phase)
      0: if (elig) begin m_int = 1; m_phase = 1; end
      1: begin
        if (fall) begin
          m_int = 0; m_freeze = 1; m_phase = 2;
          if (elig) begin m_lvl = c; m_gen = 1; set_m[c] = 1'b1; m_clr[c] = 1'b1; end
          else begin m_lvl = 7; m_gen = 0; end
        end else if (!elig) begin
          m_int = 0; m_phase = 0;
        end
      end
      2: if (fall) begin m_dout = {vector_base, m_lvl[2:0]}; m_den = 1; m_phase = 3; end
      default: if (rise) begin
        m_den = 0; m_freeze = 0; m_phase = 0;
        if (auto_eoi && m_gen) begin
          m_isr[m_lvl] = 1'b0;
          if (rotate_on_eoi) m_lp = m_lvl;
        end
      end
    endcase
    if (eoi_valid) begin
      if (eoi_specific) begin
        if (old_isr[eoi_level]) begin
          m_isr[eoi_level] = 1'b0;
          if (rotate_on_eoi) m_lp = eoi_level;
        end
      end else if (b >= 0) begin
        m_isr[b] = 1'b0;
        if (rotate_on_eoi) m_lp = b;
      end
    end
    m_isr = m_isr | set_m;
  endtask

  task automatic check_all();
    check_val("int_out", int_out, m_int);
    check_val("clear_irr", clear_irr, m_clr);
    check_val("freeze", freeze, m_freeze);
    check_val("isr", isr, m_isr);
    check_val("data_out", data_out, m_dout);
    check_val("data_out_en", data_out_en, m_den);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic ack();
    inta_n = 0; tick();
    irr = irr & ~m_clr;
    inta_n = 1; tick();
    inta_n = 0; tick();
    inta_n = 1; tick();
  endtask

  task automatic eoi_ns();
    eoi_valid = 1; eoi_specific = 0; tick();
    eoi_valid = 0;
  endtask

  initial begin
    m_reset();
    #12;
    check_val("rst_int", int_out, 0);
    check_val("rst_clr", clear_irr, 0);
    check_val("rst_freeze", freeze, 0);
    check_val("rst_isr", isr, 0);
    check_val("rst_dout", data_out, 0);
    check_val("rst_den", data_out_en, 0);
    @(negedge clk); rst_n = 1;

    // Basic handshake: IR2 wins over IR5
    irr = 8'h24; tick();
    check_val("s1_int", int_out, 1);
    inta_n = 0; tick();
    check_val("s1_clr", clear_irr, 8'h04);
    check_val("s1_isr", isr, 8'h04);
    check_val("s1_freeze", freeze, 1);
    irr = 8'h20; inta_n = 1; tick();
    inta_n = 0; tick();
    check_val("s1_dout", data_out, 8'h42);
    check_val("s1_den", data_out_en, 1);
    inta_n = 1; tick(); tick(); tick();
    check_val("s1_int_low", int_out, 0);

    // Lower priority blocked, higher priority nests
    irr = 8'h10; tick(); tick();
    check_val("s2_blocked", int_out, 0);
    irr = 8'h02; tick();
    check_val("s2_int", int_out, 1);
    ack();
    check_val("s2_isr", isr, 8'h06);
    check_val("s2_lvl", data_out[2:0], 1);

    // Non-specific EOI, then rotation
    irr = 8'h00; eoi_ns();
    check_val("s3_isr", isr, 8'h04);
    rotate_on_eoi = 1; eoi_ns(); rotate_on_eoi = 0;
    check_val("s3_isr0", isr, 8'h00);
    irr = 8'h09; tick(); ack();
    check_val("s3_rot_lvl", data_out[2:0], 3);
    check_val("s3_rot_isr", isr, 8'h08);
    irr = 8'h00; eoi_ns();
    check_val("s3_isr_clr", isr, 8'h00);

    // Request withdrawn at first INTA -> spurious
    irr = 8'h01; tick();
    check_val("s4_int", int_out, 1);
    irr = 8'h00; inta_n = 0; tick();
    check_val("s4_clr", clear_irr, 0);
    check_val("s4_isr", isr, 0);
    inta_n = 1; tick(); inta_n = 0; tick();
    check_val("s4_spur", data_out[2:0], 7);
    inta_n = 1; tick();

    // Automatic EOI
    auto_eoi = 1; irr = 8'h80; tick();
    inta_n = 0; tick();
    irr = 8'h00; inta_n = 1; tick();
    check_val("s5_isr_ack1", isr, 8'h80);
    inta_n = 0; tick();
    check_val("s5_isr_ack2", isr, 8'h80);
    inta_n = 1; tick();
    check_val("s5_isr_aeoi", isr, 8'h00);
    check_val("s5_freeze", freeze, 0);
    auto_eoi = 0;

    // Reset during ACK2
    irr = 8'h01; tick();
    inta_n = 0; tick();
    irr = 8'h00; inta_n = 1; tick();
    inta_n = 0; tick();
    check_val("s6_den", data_out_en, 1);
    #2; rst_n = 0; #1;
    check_val("s6_rst_den", data_out_en, 0);
    check_val("s6_rst_isr", isr, 0);
    check_val("s6_rst_int", int_out, 0);
    m_reset();
    inta_n = 1;
    @(negedge clk); rst_n = 1;
    irr = 8'h01; tick();
    check_val("s6_int", int_out, 1);
    ack();
    check_val("s6_isr", isr, 8'h01);
    check_val("s6_dout", data_out, 8'h40);
    irr = 8'h00; eoi_ns();

    // Randomized traffic against the reference
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0) irr = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      irr = irr & ~m_clr;
      if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
      eoi_valid     = ($urandom_range(0, 11) == 0) && (m_phase != 3);
      eoi_specific  = 1'($urandom_range(0, 1));
      eoi_level     = 3'($urandom_range(0, 7));
      rotate_on_eoi = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) auto_eoi = ~auto_eoi;
      if ($urandom_range(0, 127) == 0) vector_base = 5'($urandom_range(0, 31));
      tick();
      if ($urandom_range(0, 499) == 0) begin
        #2; rst_n = 0; #1;
        m_reset();
        check_all();
        @(negedge clk); rst_n = 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
